// File: rtl/aes0_arb_pkg.sv
// Shared types for the AES-192 job arbiter: FSM states, job operands and the
// debug-mode key policy.
package aes0_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP,
        DRAIN
    } arb_state_e;

    typedef logic [1:0]   key_sel_t;
    typedef logic [127:0] block_t;

    typedef struct packed {
        key_sel_t key_sel;
        block_t   p_c;
        block_t   state;
    } job_t;

    localparam key_sel_t KEY_SEL_DEBUG_SAFE = 2'b10;

    // In debug mode only the upper key banks (2/3) may be used.
    function automatic logic key_allowed(input logic debug_mode, input key_sel_t key_sel);
        return !debug_mode || ((key_sel & KEY_SEL_DEBUG_SAFE) != 2'b00);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around, wins.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_req_o
);

    int              sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant_o   = '0;
        winner_o  = '0;
        any_req_o = 1'b0;
        found     = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(rr_ptr_i) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = idx;
            end
        end
        any_req_o = found;
    end

endmodule

// File: rtl/aes0_job_arbiter.sv
// Round-robin job scheduler in front of one aes_192_sed engine.
// Optional engine watchdog: define AES0_ARB_WATCHDOG_EN.
module aes0_job_arbiter
    import aes0_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0][1:0]   req_key_sel_i,
    input  logic [NUM_REQ-1:0][127:0] req_p_c_i,
    input  logic [NUM_REQ-1:0][127:0] req_state_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    input  logic [NUM_REQ-1:0]        resp_ready_i,
    output logic [127:0]              resp_ct_o,
    output logic                      resp_err_o,
    input  logic                      debug_mode_i,
    output logic                      eng_start_o,
    output logic [1:0]                eng_key_sel_o,
    output logic [127:0]              eng_p_c_o,
    output logic [127:0]              eng_state_o,
    input  logic [127:0]              eng_ct_i,
    input  logic                      eng_valid_i,
    output logic                      busy_o,
    output logic [ID_W-1:0]           grant_id_o
);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_id_q;
    job_t               job_q;
    job_t               win_job;
    block_t             resp_ct_q;
    logic               resp_err_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_winner;
    logic               arb_any;

    logic               take_job;
    logic               eng_done;
    logic               wd_hit;
    logic               wd_expired;
    logic               resp_taken;
    logic               drain_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i     (req_valid_i),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (arb_grant),
        .winner_o  (arb_winner),
        .any_req_o (arb_any)
    );

    always_comb begin
        win_job.key_sel = req_key_sel_i[arb_winner];
        win_job.p_c     = req_p_c_i[arb_winner];
        win_job.state   = req_state_i[arb_winner];
    end

`ifdef AES0_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_q;

    // Counts RUN cycles; held at zero in every other state so each job starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != RUN) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end

    assign wd_hit = (state_q == RUN) && (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_hit         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        take_job   = 1'b0;
        eng_done   = 1'b0;
        wd_expired = 1'b0;
        resp_taken = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any && !rst_i) begin
                    take_job = 1'b1;
                    state_d  = key_allowed(debug_mode_i, win_job.key_sel) ? RUN : RESP;
                end
            end
            RUN: begin
                if (eng_valid_i) begin
                    eng_done = 1'b1;
                    state_d  = RESP;
                end else if (wd_hit) begin
                    wd_expired = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i[grant_id_q]) begin
                    resp_taken = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The engine may keep out_valid high after the capture.
                if (!eng_valid_i) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            job_q      <= '0;
            resp_ct_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_job) begin
                job_q      <= win_job;
                grant_id_q <= arb_winner;
                rr_ptr_q   <= (arb_winner == ID_W'(NUM_REQ - 1)) ? '0 : arb_winner + ID_W'(1);
                if (state_d == RESP) begin
                    resp_err_q <= 1'b1;
                    resp_ct_q  <= '0;
                end
            end
            if (eng_done) begin
                resp_ct_q  <= eng_ct_i;
                resp_err_q <= 1'b0;
            end
            if (wd_expired) begin
                resp_ct_q  <= '0;
                resp_err_q <= 1'b1;
            end
            if (resp_taken) begin
                resp_ct_q  <= '0;
                resp_err_q <= 1'b0;
            end
            // Scrub operands so no plaintext lingers between jobs.
            if (drain_done) begin
                job_q      <= '0;
                resp_ct_q  <= '0;
                resp_err_q <= 1'b0;
            end
        end
    end

    assign req_ready_o   = take_job ? arb_grant : '0;
    assign resp_valid_o  = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q) : '0;
    assign resp_ct_o     = resp_ct_q;
    assign resp_err_o    = resp_err_q;
    assign eng_start_o   = (state_q == RUN);
    assign eng_key_sel_o = job_q.key_sel;
    assign eng_p_c_o     = job_q.p_c;
    assign eng_state_o   = job_q.state;
    assign busy_o        = (state_q != IDLE);
    assign grant_id_o    = grant_id_q;

endmodule
